sd_cmd_phy: RTL and testbench

SD_CMD_PHY -- requirements
Module: sd_cmd_phy

---
 rtl/sd_pkg.sv | 33 +++
 rtl/sd_crc7.sv | 24 ++
 rtl/sd_cmd_phy.sv | 224 ++++++++++++++++++++++
 tb/tb_sd_cmd_phy.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SD command-line PHY: response encodings, frame
// geometry and the CRC7 step used by both the transmit and receive paths.
package sd_pkg;

    typedef enum logic [1:0] {
        RESP_NONE      = 2'b00,
        RESP_R48       = 2'b01,
        RESP_R136      = 2'b10,
        RESP_R48_NOCRC = 2'b11
    } resp_type_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX,
        ST_NCC,
        ST_WAIT,
        ST_RX
    } state_t;

    localparam int CMD_FRAME_LEN  = 48;
    localparam int LONG_FRAME_LEN = 136;
    localparam int CMD_CRC_SPAN   = 40;

    // x^7 + x^3 + 1
    localparam logic [6:0] CRC7_POLY = 7'h09;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator, one bit per enabled clock; clear has priority
// so a new frame can start on the same edge the previous one ended.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (clear) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc7_step(crc, din);
        end
    end

endmodule

// File: rtl/sd_cmd_phy.sv
// SD CMD-line PHY: serialises a 48-bit command frame, then optionally waits
// for and captures a 48- or 136-bit response, checking CRC7 and end bit.
module sd_cmd_phy
    import sd_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 64,
    parameter int NCC_TICKS     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         sd_tick,
    input  logic         start,
    input  logic [5:0]   cmd_idx,
    input  logic [31:0]  cmd_arg,
    input  logic [1:0]   resp_type,
    input  logic         cmd_i,
    output logic         cmd_o,
    output logic         cmd_oe,
    output logic         busy,
    output logic         done,
    output logic [127:0] resp,
    output logic         crc_err,
    output logic         end_err,
    output logic         timeout
);

    localparam int CNT_MAX = (TIMEOUT_TICKS > NCC_TICKS) ? TIMEOUT_TICKS : NCC_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [7:0] TX_BITS      = 8'(CMD_FRAME_LEN);
    localparam logic [7:0] TX_CRC_START = 8'(CMD_CRC_SPAN);
    localparam logic [7:0] TX_END_BIT   = 8'(CMD_FRAME_LEN - 1);

    // The RX bit counter excludes the start bit, so counter value c carries
    // frame bit LEN-2-c; the CRC covers frame bits down to bit 8.
    localparam logic [7:0] RX_SHORT_LAST    = 8'(CMD_FRAME_LEN - 2);
    localparam logic [7:0] RX_LONG_LAST     = 8'(LONG_FRAME_LEN - 2);
    localparam logic [7:0] RX_SHORT_CRC_END = 8'(CMD_FRAME_LEN - 10);
    localparam logic [7:0] RX_LONG_CRC_BEG  = 8'(LONG_FRAME_LEN - 2 - 127);
    localparam logic [7:0] RX_LONG_CRC_END  = 8'(LONG_FRAME_LEN - 10);

    state_t             state;
    logic [5:0]         idx_q;
    logic [31:0]        arg_q;
    resp_type_t         type_q;
    logic [7:0]         bit_cnt;
    logic [CNT_W-1:0]   tick_cnt;
    logic [127:0]       rx_sr;

    logic [6:0]   crc;
    logic         crc_clr;
    logic         crc_en;
    logic         crc_din;

    logic [39:0]  tx_head;
    logic         tx_bit;
    logic         is_long;
    logic [7:0]   rx_last;
    logic         rx_in_crc;
    logic [127:0] rx_next;

    assign tx_head = {2'b01, idx_q, arg_q};
    assign is_long = (type_q == RESP_R136);
    assign rx_last = is_long ? RX_LONG_LAST : RX_SHORT_LAST;
    assign rx_next = {rx_sr[126:0], cmd_i};
    assign rx_in_crc = is_long ? (bit_cnt >= RX_LONG_CRC_BEG && bit_cnt <= RX_LONG_CRC_END)
                               : (bit_cnt <= RX_SHORT_CRC_END);

    // Frame bit for the current TX position: header, then CRC, then end bit.
    always_comb begin
        tx_bit = 1'b1;
        if (bit_cnt < TX_CRC_START) begin
            tx_bit = tx_head[6'(TX_CRC_START - 8'd1 - bit_cnt)];
        end else if (bit_cnt < TX_END_BIT) begin
            tx_bit = crc[3'(TX_END_BIT - 8'd1 - bit_cnt)];
        end
    end

    always_comb begin
        crc_clr = 1'b0;
        crc_en  = 1'b0;
        crc_din = 1'b0;
        case (state)
            ST_IDLE: crc_clr = start;
            ST_TX: begin
                crc_en  = sd_tick && (bit_cnt < TX_CRC_START);
                crc_din = tx_bit;
                crc_clr = sd_tick && (bit_cnt == TX_BITS);
            end
            // The start bit belongs to the checked span only for short frames.
            ST_WAIT: crc_en = sd_tick && !cmd_i && !is_long;
            ST_RX: begin
                crc_en  = sd_tick && rx_in_crc;
                crc_din = cmd_i;
            end
            default: ;
        endcase
    end

    sd_crc7 u_crc7 (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (crc_clr),
        .en    (crc_en),
        .din   (crc_din),
        .crc   (crc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cmd_o    <= 1'b1;
            cmd_oe   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            crc_err  <= 1'b0;
            end_err  <= 1'b0;
            timeout  <= 1'b0;
            resp     <= '0;
            idx_q    <= '0;
            arg_q    <= '0;
            type_q   <= RESP_NONE;
            bit_cnt  <= '0;
            tick_cnt <= '0;
            rx_sr    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx_q    <= cmd_idx;
                        arg_q    <= cmd_arg;
                        type_q   <= resp_type_t'(resp_type);
                        crc_err  <= 1'b0;
                        end_err  <= 1'b0;
                        timeout  <= 1'b0;
                        busy     <= 1'b1;
                        bit_cnt  <= '0;
                        tick_cnt <= '0;
                        state    <= ST_TX;
                    end
                end

                ST_TX: begin
                    if (sd_tick) begin
                        if (bit_cnt < TX_BITS) begin
                            cmd_oe  <= 1'b1;
                            cmd_o   <= tx_bit;
                            bit_cnt <= bit_cnt + 8'd1;
                        end else begin
                            bit_cnt <= '0;
                            cmd_o   <= 1'b1;
                            if (type_q == RESP_NONE) begin
                                tick_cnt <= '0;
                                state    <= ST_NCC;
                            end else begin
                                // This tick already counts toward the response timeout.
                                cmd_oe   <= 1'b0;
                                tick_cnt <= CNT_W'(1);
                                state    <= ST_WAIT;
                            end
                        end
                    end
                end

                ST_NCC: begin
                    if (sd_tick) begin
                        if (tick_cnt == CNT_W'(NCC_TICKS - 1)) begin
                            cmd_oe   <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            tick_cnt <= '0;
                            state    <= ST_IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
                end

                ST_WAIT: begin
                    if (sd_tick) begin
                        if (!cmd_i) begin
                            bit_cnt  <= '0;
                            tick_cnt <= '0;
                            state    <= ST_RX;
                        end else if (tick_cnt == CNT_W'(TIMEOUT_TICKS - 1)) begin
                            timeout  <= 1'b1;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            tick_cnt <= '0;
                            state    <= ST_IDLE;
                        end else begin
                            tick_cnt <= tick_cnt + CNT_W'(1);
                        end
                    end
                end

                ST_RX: begin
                    if (sd_tick) begin
                        rx_sr   <= rx_next;
                        bit_cnt <= bit_cnt + 8'd1;
                        if (bit_cnt == rx_last) begin
                            resp    <= is_long ? rx_next : {90'b0, rx_next[45:8]};
                            crc_err <= (type_q != RESP_R48_NOCRC) && (crc != rx_next[7:1]);
                            end_err <= !rx_next[0];
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            bit_cnt <= '0;
                            state   <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    cmd_oe <= 1'b0;
                    cmd_o  <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Bench for sd_cmd_phy: a table of commands with a reactive card model and a
// scoreboard of expected completions, plus reset, freeze and busy-start cases.
module tb_sd_cmd_phy;

    localparam int NCC = 8;
    localparam int TMO = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sd_tick = 1'b0;
    logic         start = 1'b0;
    logic [5:0]   cmd_idx = '0;
    logic [31:0]  cmd_arg = '0;
    logic [1:0]   resp_type = '0;
    logic         cmd_i = 1'b1;
    logic         cmd_o;
    logic         cmd_oe;
    logic         busy;
    logic         done;
    logic [127:0] resp;
    logic         crc_err;
    logic         end_err;
    logic         timeout;

    int  n_checks = 0;
    int  n_fail = 0;
    int  tick_div = 0;
    logic tick_en = 1'b1;
    logic [127:0] model_resp = '0;

    typedef struct {
        logic [5:0]   idx;
        logic [31:0]  arg;
        logic [1:0]   rtype;
        int           reply_len;
        logic [135:0] reply;
        logic [47:0]  exp_frame;
        logic         exp_crc;
        logic         exp_end;
        logic         exp_to;
        logic         poke;
        logic         freeze;
    } vec_t;

    typedef struct {
        logic [127:0] resp;
        logic         crc_err;
        logic         end_err;
        logic         timeout;
    } exp_t;

    exp_t sb[$];
    vec_t tv[10];

    sd_cmd_phy #(.TIMEOUT_TICKS(TMO), .NCC_TICKS(NCC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sd_tick   (sd_tick),
        .start     (start),
        .cmd_idx   (cmd_idx),
        .cmd_arg   (cmd_arg),
        .resp_type (resp_type),
        .cmd_i     (cmd_i),
        .cmd_o     (cmd_o),
        .cmd_oe    (cmd_oe),
        .busy      (busy),
        .done      (done),
        .resp      (resp),
        .crc_err   (crc_err),
        .end_err   (end_err),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // One SD clock per four system clocks.
    always @(negedge clk) begin
        if (tick_div == 3) begin
            tick_div = 0;
            sd_tick  = tick_en;
        end else begin
            tick_div = tick_div + 1;
            sd_tick  = 1'b0;
        end
    end

    task automatic check_v(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Returns at the falling edge that follows the next sd_tick rising edge.
    task automatic wait_tick();
        int n;
        n = 0;
        @(posedge clk);
        while (!sd_tick && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (!sd_tick) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_wait: got no sd_tick, expected one within 200 clocks");
        end
        @(negedge clk);
    endtask

    function automatic logic [6:0] crc7_ref(input logic [135:0] bits, input int n);
        logic [6:0] c;
        logic fb;
        c = '0;
        for (int i = n - 1; i >= 0; i--) begin
            fb = bits[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] make_r48(input logic [5:0] idx, input logic [31:0] body, input logic lead);
        logic [39:0] head;
        head = {1'b0, lead, idx, body};
        return {head, crc7_ref(136'(head), 40), 1'b1};
    endfunction

    function automatic logic [135:0] make_cid(input logic [119:0] cid);
        return {8'h3F, cid, crc7_ref(136'(cid), 120), 1'b1};
    endfunction

    function automatic vec_t mkv(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rtype,
                                 input int len, input logic [135:0] reply, input logic [47:0] frame,
                                 input logic c, input logic e, input logic t,
                                 input logic poke, input logic freeze);
        vec_t v;
        v.idx = idx; v.arg = arg; v.rtype = rtype; v.reply_len = len; v.reply = reply;
        v.exp_frame = frame; v.exp_crc = c; v.exp_end = e; v.exp_to = t;
        v.poke = poke; v.freeze = freeze;
        return v;
    endfunction

    // Called at a falling edge; that edge may be the done cycle of the previous command.
    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        exp_t got_e;
        logic [47:0] frame;
        logic oe_ok;
        int n;
        int high;

        if (v.reply_len == 48) model_resp = {90'b0, v.reply[45:8]};
        else if (v.reply_len == 136) model_resp = v.reply[127:0];
        e.resp = model_resp;
        e.crc_err = v.exp_crc;
        e.end_err = v.exp_end;
        e.timeout = v.exp_to;
        sb.push_back(e);

        cmd_idx = v.idx; cmd_arg = v.arg; resp_type = v.rtype; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_b({tag, " busy_after_start"}, busy, 1'b1);
        check_b({tag, " done_pulse_width"}, done, 1'b0);
        check_v({tag, " status_cleared"}, 136'({crc_err, end_err, timeout}), 136'(0));

        frame = '0;
        oe_ok = 1'b1;
        for (int k = 0; k < 48; k++) begin
            wait_tick();
            if (!cmd_oe) oe_ok = 1'b0;
            frame = {frame[46:0], cmd_o};
            if (v.poke && k == 10) begin
                cmd_idx = ~v.idx; cmd_arg = ~v.arg; resp_type = ~v.rtype; start = 1'b1;
                @(posedge clk);
                @(negedge clk);
                start = 1'b0;
                cmd_idx = v.idx; cmd_arg = v.arg; resp_type = v.rtype;
            end
        end
        check_v({tag, " tx_frame"}, 136'(frame), 136'(v.exp_frame));
        check_b({tag, " tx_drive_enable"}, oe_ok, 1'b1);

        if (v.rtype == 2'b00) begin
            n = 0;
            high = 0;
            while (!done && n < 200) begin
                wait_tick();
                n++;
                if (!done && cmd_oe && cmd_o) high++;
            end
            check_i({tag, " ncc_high_ticks"}, high, NCC);
        end else begin
            wait_tick();
            check_b({tag, " line_released"}, cmd_oe, 1'b0);
            n = 1;
            if (v.reply_len == 0) begin
                if (v.freeze) begin
                    tick_en = 1'b0;
                    repeat (300) @(negedge clk);
                    check_v({tag, " frozen_busy_done"}, 136'({busy, done}), 136'(2'b10));
                    tick_en = 1'b1;
                end
                while (!done && n < 300) begin
                    wait_tick();
                    n++;
                end
                check_i({tag, " timeout_ticks"}, n, TMO);
            end else begin
                wait_tick();
                for (int b = v.reply_len - 1; b >= 0; b--) begin
                    cmd_i = v.reply[b];
                    wait_tick();
                end
                cmd_i = 1'b1;
                check_b({tag, " done_after_last_bit"}, done, 1'b1);
            end
        end

        if (sb.size() > 0) begin
            got_e = sb.pop_front();
            check_v({tag, " resp"}, 136'(resp), 136'(got_e.resp));
            check_v({tag, " flags_crc_end_to"}, 136'({crc_err, end_err, timeout}),
                    136'({got_e.crc_err, got_e.end_err, got_e.timeout}));
        end
        check_v({tag, " idle_busy_oe_o"}, 136'({busy, cmd_oe, cmd_o}), 136'(3'b001));
    endtask

    task automatic reset_mid_tx();
        int seen;
        cmd_idx = 6'd8; cmd_arg = 32'h1AA; resp_type = 2'b01; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (20) wait_tick();
        check_b("rst pre_oe", cmd_oe, 1'b1);
        rst_n = 1'b0;
        #1;
        check_v("rst oe_busy_done_o", 136'({cmd_oe, busy, done, cmd_o}), 136'(4'b0001));
        check_v("rst resp_flags", 136'({resp, crc_err, end_err, timeout}), 136'(0));
        model_resp = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (done) seen++;
        end
        check_i("rst no_done", seen, 0);
    endtask

    initial begin
        logic [47:0]  r7;
        logic [47:0]  r3;
        logic [119:0] cid;
        logic [135:0] cid_frame;

        r7 = 48'h08000001AA13;
        r3 = make_r48(6'h3F, 32'h80FF8000, 1'b0) ^ 48'h2;
        cid = 120'h035344534430333280_1234567_8_01_6A_C;
        cid_frame = make_cid(cid);

        tv[0] = mkv(6'd0, 32'h0, 2'b00, 0, '0, 48'h400000000095, 0, 0, 0, 0, 0);
        tv[1] = mkv(6'd8, 32'h1AA, 2'b01, 48, 136'(r7), 48'h48000001AA87, 0, 0, 0, 0, 0);
        tv[2] = mkv(6'd8, 32'h1AA, 2'b01, 48, 136'(r7 ^ 48'h4), 48'h48000001AA87, 1, 0, 0, 0, 0);
        tv[3] = mkv(6'd8, 32'h1AA, 2'b01, 48, 136'(r7 ^ 48'h1), 48'h48000001AA87, 0, 1, 0, 0, 0);
        tv[4] = mkv(6'd41, 32'h40FF8000, 2'b11, 48, 136'(r3), make_r48(6'd41, 32'h40FF8000, 1'b1), 0, 0, 0, 0, 0);
        tv[5] = mkv(6'd0, 32'h0, 2'b00, 0, '0, 48'h400000000095, 0, 0, 0, 0, 0);
        tv[6] = mkv(6'd2, 32'h0, 2'b10, 136, cid_frame, make_r48(6'd2, 32'h0, 1'b1), 0, 0, 0, 0, 0);
        tv[7] = mkv(6'd8, 32'h1AA, 2'b01, 0, '0, 48'h48000001AA87, 0, 0, 1, 0, 1);
        tv[8] = mkv(6'd55, 32'h12340000, 2'b01, 48, 136'(make_r48(6'd55, 32'h00000120, 1'b0)),
                    make_r48(6'd55, 32'h12340000, 1'b1), 0, 0, 0, 1, 0);
        tv[9] = mkv(6'd2, 32'h0, 2'b10, 136, cid_frame ^ 136'h10, make_r48(6'd2, 32'h0, 1'b1), 1, 0, 0, 0, 0);

        repeat (4) @(negedge clk);
        check_v("reset oe_busy_done_o", 136'({cmd_oe, busy, done, cmd_o}), 136'(4'b0001));
        check_v("reset resp_flags", 136'({resp, crc_err, end_err, timeout}), 136'(0));
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            if (i == 5) reset_mid_tx();
            run_vec(tv[i], $sformatf("v%0d", i));
        end

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
